alu_result_buffer: RTL and testbench
====================================

# alu_result_buffer

Registered result queue between the execute stage and the memory/writeback stage of the 64-bit pipeline. Each cycle it accepts one ALU result (64-bit value, destination register index, write-enable) over a valid/ready handshake, holds up to DEPTH results in order, and presents them to the downstream stage over a second valid/ready handshake. It decouples downstream stalls from the combinational ALU and optionally exposes buffered results for operand forwarding.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  discard all buffered entries (pipeline redirect)
- in_valid  in  1  execute stage offers a result
- in_ready  out  1  buffer can accept this cycle
- in_result  in  64 (u64)  ALU output value
- in_rd  in  5 (u5)  destination register index
- in_wen  in  1  result writes the register file
- out_valid  out  1  head entry available
- out_ready  in  1  downstream consumes head this cycle
- out_result  out  64  head value
- out_rd  out  5  head destination index
- out_wen  out  1  head write-enable
- count  out  $clog2(DEPTH+1)  current occupancy
- byp_rs  in  5  forwarding query index (only with ALU_RESULT_BYPASS_EN)
- byp_hit  out  1  a buffered entry matches byp_rs (only with ALU_RESULT_BYPASS_EN)
- byp_data  out  64  matching value (only with ALU_RESULT_BYPASS_EN)

## Operation
- Storage: DEPTH entries of {result, rd, wen}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- Push: in_valid && in_ready; entry written at tail, tail advances.
- Pop: out_valid && out_ready; head advances.
- in_ready = (count != DEPTH); derived from registered state only, never from out_ready.
- out_valid = (count != 0); out_result/out_rd/out_wen show head entry, driven 0 when empty.
- Push and pop same cycle: count unchanged, both pointers advance.
- Full with out_ready=1: pop proceeds, push refused (in_ready low); space visible next cycle.
- Empty: no pass-through; a result pushed at cycle N appears on out_* at N+1.
- flush: highest priority. Same-cycle push and pop are both ignored; next cycle count=0, head=tail=0, out_valid=0, in_ready=1.
- Entries with in_wen=0 (stores, branches) are buffered and delivered like any other.
- Order strictly FIFO; no entry dropped or duplicated except by flush/reset.

## Timing
- Reset (resetn low, asynchronous): count=0, head=tail=0, out_valid=0, in_ready=1, out_result=0, out_rd=0, out_wen=0, byp_hit=0, byp_data=0.
- Reset deasserted mid-traffic: all entries lost; first push accepted on the first rising edge with resetn high.
- Latency in→out: 1 cycle. Throughput: 1 result/cycle sustained when out_ready held high.
- count updates on the edge following the handshake.

## Configuration
- ALU_RESULT_BYPASS_EN defined: byp_rs/byp_hit/byp_data ports exist. byp_hit is combinational = some occupied entry has wen=1 && rd==byp_rs && byp_rs!=0; byp_data is the youngest such entry's result (closest to tail), else 0. Same-cycle incoming in_* and entries being flushed this cycle are not considered (flush clears next cycle).
- Not defined: bypass ports and search logic absent; all other behaviour identical.

## Test plan
- Reset, then push {0x1234, rd=5, wen=1} with out_ready=0 -> next cycle out_valid=1, out_result=0x1234, out_rd=5, count=1.
- Push 4 results with out_ready=0 -> in_ready=0 after 4th; 5th in_valid held, not accepted; out_ready=1 -> results drain in order 1,2,3,4, 5th accepted one cycle after first pop.
- out_ready=1 continuously, 8 back-to-back pushes -> every value appears exactly once, 1 cycle after push, count never exceeds 1.
- 3 entries buffered, flush=1 with in_valid=1 and out_ready=1 same cycle -> next cycle count=0, out_valid=0, no result delivered.
- With ALU_RESULT_BYPASS_EN: buffer {0xA, rd=7}, {0xB, rd=7}, {0xC, rd=3, wen=0} -> byp_rs=7 gives hit=1, data=0xB; byp_rs=3 gives hit=0; byp_rs=0 gives hit=0.
- Assert resetn low while 2 entries held -> immediately out_valid=0, count=0, in_ready=1.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Registered in-order result queue between execute and memory/writeback.
// Optional operand-forwarding search is compiled in with `define ALU_RESULT_BYPASS_EN.
module alu_result_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [63:0]                in_result,
    input  logic [4:0]                 in_rd,
    input  logic                       in_wen,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_result,
    output logic [4:0]                 out_rd,
    output logic                       out_wen,
`ifdef ALU_RESULT_BYPASS_EN
    input  logic [4:0]                 byp_rs,
    output logic                       byp_hit,
    output logic [63:0]                byp_data,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [63:0]   mem_result [DEPTH];
    logic [4:0]    mem_rd     [DEPTH];
    logic          mem_wen    [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on registered occupancy, never on out_ready, so a
    // full buffer refuses a push even in a cycle where it also pops.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: it is only observed while occupied.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_result[tail] <= in_result;
            mem_rd[tail]     <= in_rd;
            mem_wen[tail]    <= in_wen;
        end
    end

    assign out_result = out_valid ? mem_result[head] : 64'd0;
    assign out_rd     = out_valid ? mem_rd[head]     : 5'd0;
    assign out_wen    = out_valid ? mem_wen[head]    : 1'b0;

`ifdef ALU_RESULT_BYPASS_EN
    logic [PW-1:0] byp_idx;

    // Walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = 64'd0;
        byp_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            byp_idx = head + PW'(k);
            if ((CW'(k) < count) && mem_wen[byp_idx] &&
                (mem_rd[byp_idx] == byp_rs) && (byp_rs != 5'd0)) begin
                byp_hit  = 1'b1;
                byp_data = mem_result[byp_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: vector table plus a FIFO scoreboard,
// with hand-written flush, back-to-back, bypass and async-reset sequences.
module tb_alu_result_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk;
    logic          resetn;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_result;
    logic [4:0]    in_rd;
    logic          in_wen;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_result;
    logic [4:0]    out_rd;
    logic          out_wen;
    logic [CW-1:0] count;
`ifdef ALU_RESULT_BYPASS_EN
    logic [4:0]    byp_rs;
    logic          byp_hit;
    logic [63:0]   byp_data;
`endif

    alu_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
`ifdef ALU_RESULT_BYPASS_EN
        .byp_rs     (byp_rs),
        .byp_hit    (byp_hit),
        .byp_data   (byp_data),
`endif
        .count      (count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Scoreboard entries are {wen, rd, result}.
    logic [69:0] exp_q[$];

    typedef struct {
        logic          v;
        logic [63:0]   d;
        logic [4:0]    rd;
        logic          wen;
        logic          ordy;
        logic          fl;
        logic [CW-1:0] e_cnt;
        logic          e_ir;
        logic [63:0]   e_res;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle's inputs, checks current outputs against the scoreboard,
    // updates the model for the coming edge, then advances past that edge.
    task automatic cycle(input logic v, input logic [63:0] d, input logic [4:0] rd,
                         input logic wen, input logic ordy, input logic fl);
        logic [69:0] hd;
        int          sz;
        in_valid  = v;
        in_result = d;
        in_rd     = rd;
        in_wen    = wen;
        out_ready = ordy;
        flush     = fl;
        #1;
        sz = exp_q.size();
        hd = (sz != 0) ? exp_q[0] : 70'd0;
        check("in_ready",   {63'd0, in_ready},  {63'd0, sz != DEPTH});
        check("out_valid",  {63'd0, out_valid}, {63'd0, sz != 0});
        check("out_result", out_result, hd[63:0]);
        check("out_rd",     {59'd0, out_rd},   {59'd0, hd[68:64]});
        check("out_wen",    {63'd0, out_wen},  {63'd0, hd[69]});
        check("count",      {{(64-CW){1'b0}}, count}, 64'(sz));
        if (fl) begin
            exp_q.delete();
        end else begin
            if (ordy && sz != 0) void'(exp_q.pop_front());
            if (v && sz != DEPTH) exp_q.push_back({wen, rd, d});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Push 0x1234 then fill to full, hold a 5th while full, then drain.
        vecs[0]  = '{1'b1, 64'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 64'h1234};
        vecs[1]  = '{1'b1, 64'h2,    5'd2, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 64'h1234};
        vecs[2]  = '{1'b1, 64'h3,    5'd3, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 64'h1234};
        vecs[3]  = '{1'b1, 64'h4,    5'd4, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 64'h1234};
        vecs[4]  = '{1'b1, 64'h5,    5'd6, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 64'h1234};
        vecs[5]  = '{1'b1, 64'h5,    5'd6, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 64'h2};
        vecs[6]  = '{1'b1, 64'h5,    5'd6, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 64'h3};
        vecs[7]  = '{1'b0, 64'h0,    5'd0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 64'h4};
        vecs[8]  = '{1'b0, 64'h0,    5'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 64'h5};
        vecs[9]  = '{1'b0, 64'h0,    5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 64'h0};
        // Three buffered, then flush with push and pop asserted together.
        vecs[10] = '{1'b1, 64'hA1,   5'd1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 64'hA1};
        vecs[11] = '{1'b1, 64'hA2,   5'd2, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 64'hA1};
        vecs[12] = '{1'b1, 64'hA3,   5'd3, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 64'hA1};
        vecs[13] = '{1'b1, 64'hA4,   5'd4, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 64'h0};
        vecs[14] = '{1'b1, 64'hB1,   5'd9, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 64'hB1};
        vecs[15] = '{1'b0, 64'h0,    5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 64'h0};
        // Simultaneous push and pop at occupancy one.
        vecs[16] = '{1'b1, 64'hC1,   5'd1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 64'hC1};
        vecs[17] = '{1'b1, 64'hC2,   5'd2, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 64'hC2};
        vecs[18] = '{1'b0, 64'h0,    5'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 64'h0};

        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = 64'd0;
        in_rd     = 5'd0;
        in_wen    = 1'b0;
        out_ready = 1'b0;
`ifdef ALU_RESULT_BYPASS_EN
        byp_rs    = 5'd0;
`endif
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_count",     {{(64-CW){1'b0}}, count}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        check("rst_out_result", out_result, 64'd0);

        // Table-driven vectors
        for (int i = 0; i < 19; i++) begin
            cycle(vecs[i].v, vecs[i].d, vecs[i].rd, vecs[i].wen, vecs[i].ordy, vecs[i].fl);
            check($sformatf("vec%0d_count", i), {{(64-CW){1'b0}}, count}, {{(64-CW){1'b0}}, vecs[i].e_cnt});
            check($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
            check($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_cnt != 0});
            check($sformatf("vec%0d_out_result", i), out_result, vecs[i].e_res);
        end

        // Back-to-back pushes with downstream always ready.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'b1, 1'b0);
            check("b2b_count_le1", {63'd0, count <= CW'(1)}, 64'd1);
        end
        cycle(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 60; i++) begin
            cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0));
        end
        cycle(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);

`ifdef ALU_RESULT_BYPASS_EN
        cycle(1'b1, 64'hA, 5'd7, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'hB, 5'd7, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 5'd3, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        byp_rs = 5'd7;
        #1;
        check("byp7_hit",  {63'd0, byp_hit}, 64'd1);
        check("byp7_data", byp_data, 64'hB);
        byp_rs = 5'd3;
        #1;
        check("byp3_hit",  {63'd0, byp_hit}, 64'd0);
        check("byp3_data", byp_data, 64'd0);
        byp_rs = 5'd0;
        #1;
        check("byp0_hit",  {63'd0, byp_hit}, 64'd0);
        @(posedge clk);
        #1;
        cycle(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b1);
`endif

        // Asynchronous reset while two entries are held.
        cycle(1'b1, 64'hD1, 5'd1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'hD2, 5'd2, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("pre_rst_count", {{(64-CW){1'b0}}, count}, 64'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_count",     {{(64-CW){1'b0}}, count}, 64'd0);
        check("arst_in_ready",  {63'd0, in_ready},  64'd1);
        check("arst_out_result", out_result, 64'd0);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 64'h77, 5'd8, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 64'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
